// File: rtl/modport_fifo.sv
`default_nettype none
// ============================================================================
// Module      : modport_fifo
// Description : Single-clock synchronous FIFO with registered read data and
//               registered full/empty flags. The write side (we, data_in,
//               full) and read side (re, data_out, empty) are independent
//               ports sharing one clock.
// Revision    : 1.0 - initial release
// ============================================================================
module modport_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] data_in,
  input  logic             re,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int                c_ADDR_W   = $clog2(DEPTH);
  localparam logic [c_ADDR_W-1:0] c_PTR_ONE  = c_ADDR_W'(1);
  localparam logic [c_ADDR_W:0]   c_CNT_ONE  = (c_ADDR_W + 1)'(1);
  localparam logic [c_ADDR_W:0]   c_CNT_FULL = (c_ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [c_ADDR_W-1:0] r_wr_ptr;
  logic [c_ADDR_W-1:0] r_rd_ptr;
  logic [c_ADDR_W:0]   r_count;
  logic [WIDTH-1:0]    r_data_out;
  logic                r_full;
  logic                r_empty;

  logic                w_wr_ok;
  logic                w_rd_ok;
  logic [c_ADDR_W:0]   w_count_nxt;

  // Acceptance is judged from the registered flags, so a write on a full FIFO
  // is dropped even if a read frees a slot at the same edge.
  assign w_wr_ok = we & ~r_full;
  assign w_rd_ok = re & ~r_empty;

  // Next occupancy: unchanged when both or neither port is accepted.
  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_ok && !w_rd_ok) begin
      w_count_nxt = r_count + c_CNT_ONE;
    end else if (!w_wr_ok && w_rd_ok) begin
      w_count_nxt = r_count - c_CNT_ONE;
    end
  end

  // Storage array; left uninitialised on reset because the pointers keep
  // stale entries unreachable.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy and flags; flags are registered from the next count
  // so they move on the same edge as the count itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_CNT_FULL);
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Read data register; holds its value whenever no read is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_out <= '0;
    end else if (w_rd_ok) begin
      r_data_out <= r_mem[r_rd_ptr];
    end
  end

  assign data_out = r_data_out;
  assign full     = r_full;
  assign empty    = r_empty;

endmodule
`default_nettype wire

// File: tb/tb_modport_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_modport_fifo
// Description : Self-checking bench for modport_fifo. A constant vector table
//               covers reset/fill/drain, hand sequences cover wrap-around,
//               simultaneous access and mid-operation reset, and a random
//               phase is compared against a queue-based FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_modport_fifo;

  localparam int c_DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       we;
  logic       re;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a plain queue plus the last popped word.
  logic [7:0] m_q[$];
  logic [7:0] m_dout;

  typedef struct {
    logic       we;
    logic       re;
    logic [7:0] din;
    logic [7:0] dout;
    logic       full;
    logic       empty;
  } vec_t;

  vec_t tbl[34];

  modport_fifo #(.WIDTH(8), .DEPTH(c_DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .data_in  (data_in),
    .re       (re),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, let the edge happen, update model,
  // compare #1 after the edge.
  task automatic step(input logic w, input logic r, input logic [7:0] d);
    bit acc_w, acc_r;
    @(negedge clk);
    we = w; re = r; data_in = d;
    @(posedge clk);
    acc_w = w && (m_q.size() < c_DEPTH);
    acc_r = r && (m_q.size() > 0);
    if (acc_r) m_dout = m_q.pop_front();
    if (acc_w) m_q.push_back(d);
    #1;
    chk("data_out", 32'(data_out), 32'(m_dout));
    chk("full",     32'(full),     32'(m_q.size() == c_DEPTH));
    chk("empty",    32'(empty),    32'(m_q.size() == 0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    we = 0; re = 0; data_in = 8'h00;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_q.delete();
    m_dout = 8'h00;
    chk("rst_empty", 32'(empty),    32'd1);
    chk("rst_full",  32'(full),     32'd0);
    chk("rst_dout",  32'(data_out), 32'h00);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; we = 0; re = 0; data_in = 8'h00;
    m_dout = 8'h00;

    // Fill 0x01..0x10, 17th write ignored, drain 16, 17th read ignored.
    for (int i = 0; i < 16; i++)
      tbl[i] = '{1'b1, 1'b0, 8'(i + 1), 8'h00, (i == 15), 1'b0};
    tbl[16] = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0};
    for (int j = 0; j < 16; j++)
      tbl[17 + j] = '{1'b0, 1'b1, 8'h00, 8'(j + 1), 1'b0, (j == 15)};
    tbl[33] = '{1'b0, 1'b1, 8'h00, 8'h10, 1'b0, 1'b1};

    do_reset();

    for (int k = 0; k < 34; k++) begin
      step(tbl[k].we, tbl[k].re, tbl[k].din);
      chk($sformatf("tbl%0d_dout", k),  32'(data_out), 32'(tbl[k].dout));
      chk($sformatf("tbl%0d_full", k),  32'(full),     32'(tbl[k].full));
      chk($sformatf("tbl%0d_empty", k), 32'(empty),    32'(tbl[k].empty));
    end

    // Wrap-around: advance pointers by 10, then 16 words crossing index 15->0.
    do_reset();
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 8'(8'h30 + k));
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 8'h00);
    for (int k = 0; k < 16; k++) step(1'b1, 1'b0, 8'(8'hA0 + k));
    chk("wrap_full", 32'(full), 32'd1);
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 1'b1, 8'h00);
      chk("wrap_rd", 32'(data_out), 32'(8'hA0 + k));
    end
    chk("wrap_empty", 32'(empty), 32'd1);

    // Simultaneous access with 5 words stored: occupancy must stay at 5.
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 8'(8'h50 + k));
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b1, 8'(8'h60 + k));
      chk("sim_dout", 32'(data_out), (k < 5) ? 32'(8'h50 + k) : 32'(8'h60 + k - 5));
    end
    for (int k = 0; k < 5; k++) begin
      chk("sim_not_empty", 32'(empty), 32'd0);
      step(1'b0, 1'b1, 8'h00);
    end
    chk("sim_cnt5_empty", 32'(empty), 32'd1);

    // Simultaneous when full: read taken, write dropped.
    for (int k = 0; k < 16; k++) step(1'b1, 1'b0, 8'(8'hC0 + k));
    step(1'b1, 1'b1, 8'hEE);
    chk("full_we_re_full", 32'(full),     32'd0);
    chk("full_we_re_dout", 32'(data_out), 32'hC0);
    for (int k = 0; k < 15; k++) step(1'b0, 1'b1, 8'h00);
    chk("full_we_re_last", 32'(data_out), 32'hCF);
    chk("full_we_re_empty", 32'(empty), 32'd1);

    // Simultaneous when empty: write only, data_out holds.
    step(1'b1, 1'b1, 8'h77);
    chk("empty_we_re_dout",  32'(data_out), 32'hCF);
    chk("empty_we_re_empty", 32'(empty),    32'd0);
    step(1'b0, 1'b1, 8'h00);
    chk("empty_we_re_rd", 32'(data_out), 32'h77);

    // Mid-operation reset, asserted and released between edges.
    do_reset();
    for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 8'(8'h10 + k));
    step(1'b0, 1'b1, 8'h00);
    @(negedge clk);
    we = 0; re = 0;
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_empty", 32'(empty),    32'd1);
    chk("mid_rst_full",  32'(full),     32'd0);
    chk("mid_rst_dout",  32'(data_out), 32'h00);
    rst = 1'b0;
    m_q.delete();
    m_dout = 8'h00;
    step(1'b1, 1'b0, 8'h5A);
    step(1'b0, 1'b1, 8'h00);
    chk("mid_rst_5a", 32'(data_out), 32'h5A);

    // Random traffic against the queue model.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      logic w, r;
      w = ($urandom_range(0, 99) < ((k / 100) % 2 == 0 ? 70 : 35));
      r = ($urandom_range(0, 99) < ((k / 100) % 2 == 0 ? 35 : 70));
      step(w, r, 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
